// File: rtl/lockin_run_sequencer.sv
// Run sequencer for a lock-in processing chain: pulses the chain's reset,
// waits for readiness, enables it and counts results until a target is reached.
module lockin_run_sequencer #(
    parameter int CNT_W    = 32,
    parameter int SETTLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    n_results,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic [CNT_W-1:0]    timeout_cycles,
    input  logic                ready_to_calculate,
    input  logic                result_valid,
    output logic                proc_reset,
    output logic                proc_enable,
    output logic                busy,
    output logic                done,
    output logic                timed_out,
    output logic                aborted,
    output logic [CNT_W-1:0]    result_count,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WAIT  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    n_lat_reg, n_lat_next;
    logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;
    logic [CNT_W-1:0]    timeout_lat_reg, timeout_lat_next;
    logic [CNT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]    result_count_reg, result_count_next;
    logic                done_reg, done_next;
    logic                timed_out_reg, timed_out_next;
    logic                aborted_reg, aborted_next;
    logic                proc_reset_reg, proc_reset_next;
    logic                proc_enable_reg, proc_enable_next;
    logic                busy_reg, busy_next;
    logic [CNT_W-1:0]    count_sat;

    // Saturating increment of the result counter.
    assign count_sat = (&result_count_reg) ? result_count_reg
                                           : result_count_reg + CNT_W'(1);

    always_comb begin
        state_next        = state_reg;
        n_lat_next        = n_lat_reg;
        settle_cnt_next   = settle_cnt_reg;
        timeout_lat_next  = timeout_lat_reg;
        wait_cnt_next     = wait_cnt_reg;
        result_count_next = result_count_reg;
        done_next         = done_reg;
        timed_out_next    = timed_out_reg;
        aborted_next      = aborted_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    n_lat_next        = (n_results == '0) ? CNT_W'(1) : n_results;
                    // Down-counter: CLEAR lasts settle_cnt+1 cycles.
                    settle_cnt_next   = (settle_cycles == '0) ? '0
                                        : settle_cycles - SETTLE_W'(1);
                    timeout_lat_next  = timeout_cycles;
                    wait_cnt_next     = '0;
                    result_count_next = '0;
                    done_next         = 1'b0;
                    timed_out_next    = 1'b0;
                    aborted_next      = 1'b0;
                    state_next        = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    aborted_next = 1'b1;
                    state_next   = S_IDLE;
                end else if (settle_cnt_reg == '0) begin
                    wait_cnt_next = '0;
                    state_next    = S_WAIT;
                end else begin
                    settle_cnt_next = settle_cnt_reg - SETTLE_W'(1);
                end
            end
            S_WAIT: begin
                if (abort) begin
                    aborted_next = 1'b1;
                    state_next   = S_IDLE;
                end else if (ready_to_calculate) begin
                    state_next = S_RUN;
                end else if (timeout_lat_reg != '0) begin
                    if (wait_cnt_reg == timeout_lat_reg) begin
                        timed_out_next = 1'b1;
                        state_next     = S_DONE;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    aborted_next = 1'b1;
                    state_next   = S_IDLE;
                end else if (result_valid) begin
                    result_count_next = count_sat;
                    if (count_sat == n_lat_reg) begin
                        done_next  = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Chain controls follow the upcoming state so they are registered with it.
        proc_reset_next  = (state_next == S_CLEAR);
        proc_enable_next = (state_next == S_RUN);
        busy_next        = (state_next == S_CLEAR) || (state_next == S_WAIT)
                           || (state_next == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            n_lat_reg        <= CNT_W'(1);
            settle_cnt_reg   <= '0;
            timeout_lat_reg  <= '0;
            wait_cnt_reg     <= '0;
            result_count_reg <= '0;
            done_reg         <= 1'b0;
            timed_out_reg    <= 1'b0;
            aborted_reg      <= 1'b0;
            proc_reset_reg   <= 1'b0;
            proc_enable_reg  <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            n_lat_reg        <= n_lat_next;
            settle_cnt_reg   <= settle_cnt_next;
            timeout_lat_reg  <= timeout_lat_next;
            wait_cnt_reg     <= wait_cnt_next;
            result_count_reg <= result_count_next;
            done_reg         <= done_next;
            timed_out_reg    <= timed_out_next;
            aborted_reg      <= aborted_next;
            proc_reset_reg   <= proc_reset_next;
            proc_enable_reg  <= proc_enable_next;
            busy_reg         <= busy_next;
        end
    end

    assign proc_reset   = proc_reset_reg;
    assign proc_enable  = proc_enable_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign timed_out    = timed_out_reg;
    assign aborted      = aborted_reg;
    assign result_count = result_count_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_lockin_run_sequencer.sv
// Directed bench for lockin_run_sequencer: expectations are queued as stimulus
// is driven and popped when the corresponding DUT outputs are observed.
module tb_lockin_run_sequencer;

    localparam int CNT_W    = 32;
    localparam int SETTLE_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [CNT_W-1:0]    n_results = '0;
    logic [SETTLE_W-1:0] settle_cycles = '0;
    logic [CNT_W-1:0]    timeout_cycles = '0;
    logic                ready_to_calculate = 1'b0;
    logic                result_valid = 1'b0;
    logic                proc_reset, proc_enable, busy, done, timed_out, aborted;
    logic [CNT_W-1:0]    result_count;
    logic [2:0]          state;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    lockin_run_sequencer #(.CNT_W(CNT_W), .SETTLE_W(SETTLE_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .n_results          (n_results),
        .settle_cycles      (settle_cycles),
        .timeout_cycles     (timeout_cycles),
        .ready_to_calculate (ready_to_calculate),
        .result_valid       (result_valid),
        .proc_reset         (proc_reset),
        .proc_enable        (proc_enable),
        .busy               (busy),
        .done               (done),
        .timed_out          (timed_out),
        .aborted            (aborted),
        .result_count       (result_count),
        .state              (state)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
            $display("check %-14s observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int k = 0;
        while (state !== s && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        assert (state === s) else begin
            n_err++;
            $error("FAIL %s: state %0d expected %0d within %0d cycles", tag, state, s, budget);
        end
    endtask

    // Count consecutive sampled cycles with proc_reset high.
    task automatic count_clear(output int cnt);
        int k = 0;
        cnt = 0;
        while (proc_reset === 1'b1 && k < 100) begin
            cnt++;
            tick();
            k++;
        end
    endtask

    task automatic go_run(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state(ST_RUN, 200, tag);
    endtask

    initial begin : stim
        int cnt;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        push("rst_state", ST_IDLE); push("rst_busy", 0); push("rst_prst", 0);
        push("rst_pen", 0); push("rst_done", 0); push("rst_count", 0);
        pop_chk(state); pop_chk(busy); pop_chk(proc_reset);
        pop_chk(proc_enable); pop_chk(done); pop_chk(result_count);
        reset = 1'b0;
        tick();

        // Normal run: settle 3, n 4, ready high
        settle_cycles = 3; n_results = 4; timeout_cycles = 0; ready_to_calculate = 1'b1;
        push("norm_clr_len", 3); push("norm_wait", ST_WAIT); push("norm_run", ST_RUN);
        push("norm_pen", 1); push("norm_busy", 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        count_clear(cnt);
        pop_chk(cnt);
        pop_chk(state);
        tick();
        pop_chk(state); pop_chk(proc_enable); pop_chk(busy);
        push("norm_done", 1); push("norm_count", 4); push("norm_st_done", ST_DONE);
        push("norm_pen_off", 0);
        result_valid = 1'b1;
        repeat (4) tick();
        result_valid = 1'b0;
        pop_chk(done); pop_chk(result_count); pop_chk(state); pop_chk(proc_enable);
        push("norm_idle", ST_IDLE);
        tick();
        pop_chk(state);

        // Timeout with ready held low
        settle_cycles = 1; n_results = 1; timeout_cycles = 10; ready_to_calculate = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state(ST_WAIT, 20, "to_wait");
        push("to_cycles", 12); push("to_flag", 1); push("to_done", 0);
        cnt = 0;
        while (state !== ST_IDLE && cnt < 50) begin
            tick();
            cnt++;
        end
        pop_chk(cnt); pop_chk(timed_out); pop_chk(done);

        // Zero settings
        settle_cycles = 0; n_results = 0; timeout_cycles = 0; ready_to_calculate = 1'b1;
        push("zero_clr_len", 1); push("zero_done", 1); push("zero_count", 1);
        push("zero_timed", 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        count_clear(cnt);
        pop_chk(cnt);
        wait_state(ST_RUN, 10, "zero_run");
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        pop_chk(done); pop_chk(result_count); pop_chk(timed_out);
        tick();

        // Abort colliding with the final result beat
        settle_cycles = 1; n_results = 2;
        go_run("ab_run");
        result_valid = 1'b1;
        tick();
        push("ab_aborted", 1); push("ab_done", 0); push("ab_state", ST_IDLE);
        push("ab_pen", 0); push("ab_busy", 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        result_valid = 1'b0;
        pop_chk(aborted); pop_chk(done); pop_chk(state); pop_chk(proc_enable); pop_chk(busy);

        // Reset in the middle of a run
        n_results = 5;
        go_run("rr_run");
        result_valid = 1'b1;
        repeat (2) tick();
        result_valid = 1'b0;
        push("rr_count2", 2);
        pop_chk(result_count);
        push("rr_state", ST_IDLE); push("rr_count", 0); push("rr_pen", 0);
        push("rr_busy", 0); push("rr_prst", 0); push("rr_aborted", 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pop_chk(state); pop_chk(result_count); pop_chk(proc_enable);
        pop_chk(busy); pop_chk(proc_reset); pop_chk(aborted);
        n_results = 1; settle_cycles = 2;
        go_run("rr_rerun");
        push("rr_re_done", 1); push("rr_re_count", 1);
        result_valid = 1'b1;
        tick();
        result_valid = 1'b0;
        pop_chk(done); pop_chk(result_count);
        tick();

        // Ignored start in RUN, parameter change mid-run, ready drop in RUN
        n_results = 3; settle_cycles = 1;
        go_run("ig_run");
        n_results = 100;
        ready_to_calculate = 1'b0;
        push("ig_state", ST_RUN); push("ig_count", 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        pop_chk(state); pop_chk(result_count);
        push("ig_done", 1); push("ig_count3", 3);
        result_valid = 1'b1;
        repeat (3) tick();
        result_valid = 1'b0;
        pop_chk(done); pop_chk(result_count);
        tick();
        push("ig_sticky", 1);
        tick();
        pop_chk(done);
        push("ig_new_done", 0); push("ig_new_count", 0); push("ig_new_state", ST_CLEAR);
        ready_to_calculate = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        pop_chk(done); pop_chk(result_count); pop_chk(state);
        push("ig_abort", 1); push("ig_ab_state", ST_IDLE);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        pop_chk(aborted); pop_chk(state);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
